// File: rtl/bram_fc_engine.sv
// bram_fc_engine: streams N words from node/weight BRAMs and runs NUM_LANE saturating MACs.
// Optional macro BRAM_FC_RELU_EN clamps negative signed results to zero at o_result only.
module bram_fc_engine #(
  parameter int NUM_LANE      = 8,
  parameter int IN_DATA_WIDTH = 8,
  parameter int ACC_WIDTH     = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int CNT_WIDTH     = 31,
  parameter int RD_LAT        = 1,
  parameter int ADDR_STEP     = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              i_run,
  input  logic [CNT_WIDTH-1:0]              i_num_cnt,
  input  logic [ADDR_WIDTH-1:0]             i_base_addr,
  input  logic                              i_signed,
  output logic                              o_idle,
  output logic                              o_run,
  output logic                              o_drain,
  output logic                              o_done,
  output logic                              o_result_valid,
  output logic [NUM_LANE-1:0]               o_sat,
  output logic [ADDR_WIDTH-1:0]             addr_0,
  output logic [ADDR_WIDTH-1:0]             addr_1,
  output logic                              ce_0,
  output logic                              ce_1,
  output logic                              we_0,
  output logic                              we_1,
  output logic [NUM_LANE*IN_DATA_WIDTH-1:0] din_0,
  output logic [NUM_LANE*IN_DATA_WIDTH-1:0] din_1,
  input  logic [NUM_LANE*IN_DATA_WIDTH-1:0] dout_0,
  input  logic [NUM_LANE*IN_DATA_WIDTH-1:0] dout_1,
  output logic [NUM_LANE*ACC_WIDTH-1:0]     o_result
);
  localparam int W  = IN_DATA_WIDTH;
  localparam int DW = NUM_LANE * W;
  localparam int PW = 2 * W;
  localparam int EW = ACC_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                             state_q, state_d;
  logic [CNT_WIDTH-1:0]               cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]              addr_q, addr_d;
  logic                               signed_q, signed_d;
  logic [1:0]                         drain_q, drain_d;
  logic                               rv_q, rv_d;
  logic                               start;
  logic [RD_LAT-1:0]                  vld_sr_q;
  logic                               prod_vld_q;
  logic [NUM_LANE-1:0][PW-1:0]        prod_q, prod_d;
  logic [NUM_LANE-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
  logic [NUM_LANE-1:0]                sat_q, sat_d;
  logic [PW-1:0]                      n_ext, w_ext;
  logic [EW-1:0]                      a_ext, p_ext, sum;
  logic                               ce;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    signed_d = signed_q;
    drain_d  = drain_q;
    rv_d     = rv_q;
    start    = 1'b0;
    unique case (state_q)
      S_IDLE: if (i_run) begin
        start    = 1'b1;
        signed_d = i_signed;
        addr_d   = i_base_addr;
        cnt_d    = i_num_cnt;
        drain_d  = '0;
        rv_d     = (i_num_cnt == '0);
        state_d  = (i_num_cnt == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        addr_d = addr_q + ADDR_WIDTH'(ADDR_STEP);
        cnt_d  = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) state_d = S_DRAIN;
      end
      // RD_LAT cycles for the last read plus one for the accumulate stage
      S_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'(RD_LAT)) begin
          state_d = S_DONE;
          rv_d    = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    prod_d = '0;
    n_ext  = '0;
    w_ext  = '0;
    for (int unsigned i = 0; i < NUM_LANE; i++) begin
      n_ext = signed_q ? PW'($signed(dout_0[DW-1-i*W -: W])) : PW'(dout_0[DW-1-i*W -: W]);
      w_ext = signed_q ? PW'($signed(dout_1[DW-1-i*W -: W])) : PW'(dout_1[DW-1-i*W -: W]);
      prod_d[i] = n_ext * w_ext;
    end
  end

  // One guard bit: signed overflow shows as disagreeing top bits, unsigned as a carry out
  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    a_ext = '0;
    p_ext = '0;
    sum   = '0;
    if (start) begin
      acc_d = '0;
      sat_d = '0;
    end else if (prod_vld_q) begin
      for (int unsigned i = 0; i < NUM_LANE; i++) begin
        a_ext = signed_q ? EW'($signed(acc_q[i])) : EW'(acc_q[i]);
        p_ext = signed_q ? EW'($signed(prod_q[i])) : EW'(prod_q[i]);
        sum   = a_ext + p_ext;
        if (signed_q && (sum[EW-1] != sum[EW-2])) begin
          acc_d[i] = sum[EW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
          sat_d[i] = 1'b1;
        end else if (!signed_q && sum[EW-1]) begin
          acc_d[i] = '1;
          sat_d[i] = 1'b1;
        end else begin
          acc_d[i] = sum[ACC_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      signed_q   <= 1'b0;
      drain_q    <= '0;
      rv_q       <= 1'b0;
      vld_sr_q   <= '0;
      prod_vld_q <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      sat_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      signed_q   <= signed_d;
      drain_q    <= drain_d;
      rv_q       <= rv_d;
      vld_sr_q   <= (vld_sr_q << 1) | RD_LAT'(ce);
      prod_vld_q <= vld_sr_q[RD_LAT-1] & ~start;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
    end
  end

  assign ce             = (state_q == S_RUN);
  assign ce_0           = ce;
  assign ce_1           = ce;
  assign addr_0         = ce ? addr_q : '0;
  assign addr_1         = ce ? addr_q : '0;
  assign we_0           = 1'b0;
  assign we_1           = 1'b0;
  assign din_0          = '0;
  assign din_1          = '0;
  assign o_idle         = (state_q == S_IDLE);
  assign o_run          = (state_q == S_RUN);
  assign o_drain        = (state_q == S_DRAIN);
  assign o_done         = (state_q == S_DONE);
  assign o_result_valid = rv_q;
  assign o_sat          = sat_q;

  always_comb begin
    o_result = '0;
    for (int unsigned i = 0; i < NUM_LANE; i++) begin
      o_result[(NUM_LANE-i)*ACC_WIDTH-1 -: ACC_WIDTH] = acc_q[i];
`ifdef BRAM_FC_RELU_EN
      if (signed_q && acc_q[i][ACC_WIDTH-1]) o_result[(NUM_LANE-i)*ACC_WIDTH-1 -: ACC_WIDTH] = '0;
`endif
    end
  end

endmodule

// File: tb/tb_bram_fc_engine.sv
// Scoreboard bench for bram_fc_engine: integer reference model, BRAM model, decoupled monitor.
module tb_bram_fc_engine;
  localparam int NL   = 8;
  localparam int W    = 8;
  localparam int ACC  = 17;
  localparam int AW   = 16;
  localparam int CW   = 8;
  localparam int RDL  = 3;
  localparam int STEP = 8;
  localparam int DW   = NL * W;
  localparam int RW   = NL * ACC;

  logic clk = 1'b0;
  logic reset_n, i_run, i_signed;
  logic [CW-1:0] i_num_cnt;
  logic [AW-1:0] i_base_addr, addr_0, addr_1;
  logic o_idle, o_run, o_drain, o_done, o_result_valid, ce_0, ce_1, we_0, we_1;
  logic [NL-1:0] o_sat;
  logic [DW-1:0] din_0, din_1, dout_0, dout_1;
  logic [RW-1:0] o_result;

  typedef struct {
    logic [RW-1:0] res;
    logic [NL-1:0] sat;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] mem0[logic [AW-1:0]];
  logic [DW-1:0] mem1[logic [AW-1:0]];
  logic [DW-1:0] pipe0[RDL];
  logic [DW-1:0] pipe1[RDL];
  int            checks = 0;
  int            fails  = 0;
  int            cyc    = 0;
  logic [RW-1:0] hold_res;
  bit            have_hold = 0;
  exp_t          me;
  logic [AW-1:0] ma;

  bram_fc_engine #(
    .NUM_LANE(NL), .IN_DATA_WIDTH(W), .ACC_WIDTH(ACC), .ADDR_WIDTH(AW),
    .CNT_WIDTH(CW), .RD_LAT(RDL), .ADDR_STEP(STEP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_cnt(i_num_cnt),
    .i_base_addr(i_base_addr), .i_signed(i_signed),
    .o_idle(o_idle), .o_run(o_run), .o_drain(o_drain), .o_done(o_done),
    .o_result_valid(o_result_valid), .o_sat(o_sat),
    .addr_0(addr_0), .addr_1(addr_1), .ce_0(ce_0), .ce_1(ce_1),
    .we_0(we_0), .we_1(we_1), .din_0(din_0), .din_1(din_1),
    .dout_0(dout_0), .dout_1(dout_1), .o_result(o_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: RDL-cycle read pipeline, garbage when not enabled
  always @(posedge clk) begin
    pipe0[0] <= (ce_0 && mem0.exists(addr_0)) ? mem0[addr_0] : {$urandom(), $urandom()};
    pipe1[0] <= (ce_1 && mem1.exists(addr_1)) ? mem1[addr_1] : {$urandom(), $urandom()};
    for (int i = 1; i < RDL; i++) begin
      pipe0[i] <= pipe0[i-1];
      pipe1[i] <= pipe1[i-1];
    end
  end
  assign dout_0 = pipe0[RDL-1];
  assign dout_1 = pipe1[RDL-1];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic void model(input logic [AW-1:0] base, input int n, input bit sgn,
                                output logic [RW-1:0] res, output logic [NL-1:0] sat);
    longint acc, x, y;
    longint smax = (64'sd1 <<< (ACC-1)) - 1;
    longint smin = -(64'sd1 <<< (ACC-1));
    longint umax = (64'sd1 <<< ACC) - 1;
    logic [AW-1:0] a;
    logic [DW-1:0] w0, w1;
    logic [W-1:0] b0, b1;
    res = '0;
    sat = '0;
    for (int l = 0; l < NL; l++) begin
      acc = 0;
      for (int k = 0; k < n; k++) begin
        a  = base + AW'(k * STEP);
        w0 = mem0[a];
        w1 = mem1[a];
        b0 = w0[DW-1-l*W -: W];
        b1 = w1[DW-1-l*W -: W];
        x  = sgn ? longint'($signed(b0)) : longint'(b0);
        y  = sgn ? longint'($signed(b1)) : longint'(b1);
        acc += x * y;
        if (sgn && acc > smax) begin acc = smax; sat[l] = 1'b1; end
        else if (sgn && acc < smin) begin acc = smin; sat[l] = 1'b1; end
        else if (!sgn && acc > umax) begin acc = umax; sat[l] = 1'b1; end
      end
`ifdef BRAM_FC_RELU_EN
      if (sgn && acc < 0) acc = 0;
`endif
      res[(NL-l)*ACC-1 -: ACC] = acc[ACC-1:0];
    end
  endfunction

  // Monitor: address stream every cycle, result record on each o_done
  always @(negedge clk) begin
    chk("tied_outputs", 256'({we_0, we_1, din_0, din_1}), 256'(0));
    if (ce_0 || ce_1) begin
      if (addr_q.size() == 0) begin
        chk("unexpected_ce", 256'({ce_0, ce_1}), 256'(0));
      end else begin
        ma = addr_q.pop_front();
        chk("read_addr", 256'({ce_0, ce_1, addr_0, addr_1}), 256'({2'b11, ma, ma}));
      end
    end else begin
      chk("idle_addr", 256'({addr_0, addr_1}), 256'(0));
    end
    if (o_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 256'(o_done), 256'(0));
      end else begin
        me = exp_q.pop_front();
        chk("result", 256'(o_result), 256'(me.res));
        chk("sat", 256'(o_sat), 256'(me.sat));
        chk("valid_at_done", 256'(o_result_valid), 256'(1));
        chk("done_cycle", 256'(cyc), 256'(me.cyc));
        hold_res  = me.res;
        have_hold = 1'b1;
      end
    end else if (o_result_valid && have_hold) begin
      chk("held_result", 256'(o_result), 256'(hold_res));
    end
  end

  task automatic fill(input logic [AW-1:0] base, input int n, input int mode,
                      input logic [W-1:0] c0, input logic [W-1:0] c1, input int n_push);
    logic [AW-1:0] a;
    logic [DW-1:0] w0, w1;
    for (int k = 0; k < n; k++) begin
      a  = base + AW'(k * STEP);
      w0 = {$urandom(), $urandom()};
      w1 = {$urandom(), $urandom()};
      if (mode == 1) begin
        w0 = {NL{c0}};
        w1 = {NL{c1}};
      end else if (mode == 2) begin
        w0[DW-1 -: W] = (k == 0) ? 8'hFB : 8'd3;
        w1[DW-1 -: W] = (k == 0) ? 8'd4 : 8'd2;
      end
      mem0[a] = w0;
      mem1[a] = w1;
      if (k < n_push) addr_q.push_back(a);
    end
  endtask

  task automatic start(input logic [AW-1:0] base, input int n, input bit sgn);
    @(negedge clk);
    i_num_cnt   = CW'(n);
    i_base_addr = base;
    i_signed    = sgn;
    i_run       = 1'b1;
    @(negedge clk);
    i_run       = 1'b0;
    i_num_cnt   = CW'($urandom());
    i_base_addr = AW'($urandom());
    i_signed    = 1'($urandom());
  endtask

  task automatic run(input logic [AW-1:0] base, input int n, input bit sgn, input int mode,
                     input logic [W-1:0] c0, input logic [W-1:0] c1,
                     input bit chatter, input bit drop_test);
    exp_t e;
    int   guard;
    fill(base, n, mode, c0, c1, n);
    model(base, n, sgn, e.res, e.sat);
    e.cyc = cyc + 1 + ((n == 0) ? 1 : n + RDL + 2);
    exp_q.push_back(e);
    start(base, n, sgn);
    guard = 0;
    while (!o_done && guard < 300) begin
      if (chatter) i_run = 1'($urandom());
      @(negedge clk);
      guard++;
    end
    chk("done_timeout", 256'(guard >= 300), 256'(0));
    if (guard >= 300) exp_q.delete();
    // an i_run seen in DONE must be dropped; zero count would otherwise show as DONE again
    i_run     = drop_test;
    i_num_cnt = '0;
    @(negedge clk);
    i_run = 1'b0;
    chk("post_done_flags", 256'({o_idle, o_run, o_drain, o_done, o_result_valid}), 256'(5'b10001));
    chk("addr_leftover", 256'(addr_q.size()), 256'(0));
    addr_q.delete();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    i_run       = 1'b0;
    i_num_cnt   = '0;
    i_base_addr = '0;
    i_signed    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_flags", 256'({o_idle, o_run, o_drain, o_done, o_result_valid, ce_0, ce_1}), 256'(7'b1000000));
    chk("reset_result", 256'({o_sat, o_result}), 256'(0));
    reset_n = 1'b1;

    run(16'h0000, 4, 1'b0, 1, 8'd2,   8'd3,   1'b0, 1'b1);
    run(16'h0040, 2, 1'b1, 2, 8'd0,   8'd0,   1'b0, 1'b0);
    run(16'h0080, 4, 1'b0, 1, 8'd255, 8'd255, 1'b0, 1'b0);
    run(16'h00C0, 8, 1'b1, 1, 8'h80,  8'h7F,  1'b0, 1'b0);
    run(16'h0200, 0, 1'b1, 0, 8'd0,   8'd0,   1'b0, 1'b1);
    run(16'h0100, 3, 1'b1, 0, 8'd0,   8'd0,   1'b1, 1'b0);
    run(16'hFFF0, 4, 1'b0, 0, 8'd0,   8'd0,   1'b1, 1'b0);

    // abort two cycles into RUN, then a clean re-run
    fill(16'h0300, 6, 0, 8'd0, 8'd0, 2);
    start(16'h0300, 6, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_flags", 256'({o_idle, o_run, o_drain, o_done, o_result_valid, ce_0, ce_1}), 256'(7'b1000000));
    chk("abort_result", 256'({o_sat, o_result, addr_0}), 256'(0));
    reset_n = 1'b1;
    chk("abort_addr_leftover", 256'(addr_q.size()), 256'(0));
    addr_q.delete();
    run(16'h0300, 6, 1'b1, 0, 8'd0, 8'd0, 1'b1, 1'b0);

    for (int r = 0; r < 12; r++)
      run(AW'($urandom()), int'($urandom_range(1, 12)), 1'($urandom()), 0, 8'd0, 8'd0, 1'b1, 1'($urandom()));

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/bram_fc_engine.md
# bram_fc_engine

Parametrised fully-connected dot-product engine: streams `i_num_cnt` words from two BRAMs (node and weight) and accumulates NUM_LANE independent lane-wise multiply-accumulates in parallel. It is the generalised successor of the fixed 8-lane, 8-bit BRAM-to-FC block and sits between the AXI4-lite control registers and the two BRAM ports.

Relative to the 8-lane block it adds:
- configurable lane count, read latency, address step and base address;
- an internal MAC pipeline with saturation and a signed/unsigned mode;
- a held result-valid flag.

## Interface
Parameters:
- NUM_LANE, 8, number of parallel MAC lanes (1..16)
- IN_DATA_WIDTH, 8, element width per lane
- ACC_WIDTH, 32, accumulator / result width per lane (≥ 2*IN_DATA_WIDTH+1)
- ADDR_WIDTH, 32, BRAM address width
- CNT_WIDTH, 31, width of `i_num_cnt`
- RD_LAT, 1, BRAM read latency in cycles (1..3)
- ADDR_STEP, 8, address increment per word

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- i_run  in  1  start pulse, sampled only in IDLE
- i_num_cnt  in  CNT_WIDTH  number of words to process
- i_base_addr  in  ADDR_WIDTH  first BRAM address
- i_signed  in  1  1 = two's-complement operands, 0 = unsigned
- o_idle / o_run / o_drain / o_done  out  1 each  state flags
- o_result_valid  out  1  results stable
- o_sat  out  NUM_LANE  per-lane sticky saturation flag
- addr_0, addr_1  out  ADDR_WIDTH  BRAM addresses (identical)
- ce_0, ce_1  out  1  read enables
- we_0, we_1  out  1  tied 0
- din_0, din_1  out  NUM_LANE*IN_DATA_WIDTH  tied 0
- dout_0  in  NUM_LANE*IN_DATA_WIDTH  node word
- dout_1  in  NUM_LANE*IN_DATA_WIDTH  weight word
- o_result  out  NUM_LANE*ACC_WIDTH  packed accumulators

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE→RUN when `i_run` is high and `i_num_cnt` ≠ 0.
- IDLE→DONE when `i_run` is high and `i_num_cnt` = 0. No reads are issued and all results are 0.
- RUN→DRAIN after the N-th read is issued.
- DRAIN→DONE after RD_LAT+1 cycles.
- DONE→IDLE unconditionally.
- `i_run` is ignored outside IDLE.
- On an accepted `i_run`, the block latches `i_num_cnt`, `i_base_addr` and `i_signed`, and clears all accumulators, `o_sat` and `o_result_valid`.
- In RUN, `ce_*` is 1 and `addr_*` = base + k*ADDR_STEP for k = 0..N-1, one word per cycle.
- In every other state, `ce_*` is 0 and `addr_*` = 0.
- Data is captured from `dout_*` exactly RD_LAT cycles after each `ce`, qualified by a RD_LAT-deep valid shift register.
- Lane packing: lane 0 occupies the MSB slice, e.g. `dout[NUM_LANE*W-1 -: W]`. Lane i result is at `o_result[(NUM_LANE-i)*ACC_WIDTH-1 -: ACC_WIDTH]`.
- MAC pipeline:
  - stage 1 registers the 2W-bit product, signed or unsigned per the latched `i_signed`;
  - stage 2 adds the product into the accumulator.
- Accumulation saturates:
  - signed mode clamps to ±(2^(ACC_WIDTH-1)) bounds;
  - unsigned mode clamps to 2^ACC_WIDTH-1;
  - a clamp sets the lane's sticky `o_sat` bit.
- `o_result_valid` rises in the DONE cycle and is held until the next accepted `i_run`. `o_result` is stable while it is high.
- Reset value of every output is 0. The state is IDLE, so `o_idle` = 1.
- Reset asserted mid-operation aborts on the next edge. No further `ce` is issued and results are 0.

## Timing
- `i_run` accepted at edge 0. RUN occupies cycles 1..N, with the first `ce` in cycle 1.
- DRAIN occupies cycles N+1..N+RD_LAT+1. DONE is cycle N+RD_LAT+2.
- Total time from `i_run` to `o_done` = N+RD_LAT+2 cycles.
- For N = 0, DONE occurs in cycle 1.
- `o_done` is a single-cycle pulse. `o_idle` returns in cycle N+RD_LAT+3.
- An `i_run` asserted in the DONE cycle is dropped. It is accepted from the first IDLE cycle.
- The address counter is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH with no error flag.

## Configuration
- The macro BRAM_FC_RELU_EN controls output ReLU.
- With BRAM_FC_RELU_EN defined:
  - in signed mode, `o_result` presents max(acc, 0) per lane;
  - the internal accumulator keeps the true value;
  - `o_sat` is unaffected.
- Without the macro, `o_result` is the raw accumulator.
- Unsigned mode is identical in both builds.

## Test plan
- **Basic 8-lane run:** NUM_LANE=8, RD_LAT=1, N=4, unsigned, every node byte 2 and weight byte 3 → `o_done` in cycle 7. Every lane = 24. Addresses 0, 8, 16, 24.
- **Signed run with ReLU:** N=2, lane 0 products −5*4 and 3*2 → acc = −14. `o_result` lane 0 = −14, or 0 with BRAM_FC_RELU_EN defined.
- **Saturation:** ACC_WIDTH=17, W=8, unsigned, N=4, all bytes 255 → lane clamps to 131071 and `o_sat` = all 1s.
- **Zero count:** `i_num_cnt`=0 → `o_done` in cycle 1, `ce` never asserted, results 0, `o_result_valid` = 1.
- **Latency and base address:** RD_LAT=3, base = 0x100, N=3 → addresses 0x100, 0x108, 0x110. `o_done` in cycle 8. Results match the reference model.
- **Abort and re-run:** `reset_n` low in cycle 2 of RUN → all outputs 0 on the next edge. A re-run then completes with correct results; `i_run` pulses during RUN/DRAIN are ignored.
